add_sub_pipe: RTL and testbench
===============================

// Module: add_sub_pipe
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor for the EX stage ALU.
//   Successor to the single-cycle 64-bit ripple adder: adds ADD/SUB mode, carry/zero flags,
//   a carry chain split across STAGES register stages, and a valid/ready handshake with stall.
//   Sits between the decode/operand-fetch register and the ALU result mux / condition codes.
// PARAMETERS
//   WIDTH   64  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth; stage k adds bit slice [k*CH +: CH], CH = WIDTH/STAGES; 1 <= STAGES <= WIDTH
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand set presented
//   in_ready   out  1      block accepts operands this cycle
//   in_a       in   WIDTH  signed operand A
//   in_b       in   WIDTH  signed operand B
//   in_sub     in   1      0: A+B, 1: A-B
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result this cycle
//   out_sum    out  WIDTH  result (A+B or A-B, mod 2^WIDTH)
//   out_cout   out  1      raw carry out of MSB (SUB: 1 = no borrow)
//   out_ovf    out  1      signed overflow
//   out_zero   out  1      out_sum == 0
// BEHAVIOUR
//   - Reset: all stage valid bits 0; out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
//     in_ready=1 out of reset (pipe empty). Reset mid-operation discards every in-flight item.
//   - SUB: B operand inverted and carry-in forced to 1 at stage 0; ADD: B as is, carry-in 0.
//   - Stage k: adds slice k of A, B' plus carry registered from stage k-1; registers slice sum,
//     slice carry out, remaining upper operand slices, and already-computed lower sum slices (skew).
//   - Latency: accepted item appears on outputs exactly STAGES cycles later when not stalled.
//     Throughput 1 item/cycle.
//   - Flags computed in final stage: ovf = (a_msb == b'_msb) && (sum_msb != a_msb);
//     cout = carry out of bit WIDTH-1; zero = ~|sum. Flags valid only with out_valid.
//   - Handshake: advance = !out_valid || out_ready. in_ready = advance (combinational).
//     Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
//   - Stall (out_valid && !out_ready): every stage holds, outputs stable, in_ready=0;
//     no item dropped, duplicated or reordered. Bubbles propagate as valid=0 stages.
//   - Simultaneous out transfer and in transfer in the same cycle is legal; pipe shifts by one.
//   - in_a/in_b/in_sub ignored when in_valid=0 or in_ready=0; stage data of invalid slots is don't-care
//     but out_sum/flags hold last valid values while out_valid=0.
//   - STAGES=1: single registered adder, latency 1; same handshake.
// TESTING (WIDTH=64, STAGES=4 unless noted)
//   - ADD 0x7FFF_FFFF_FFFF_FFFF + 0x2 -> after 4 cyc sum=0x8000_0000_0000_0001, ovf=1, cout=0, zero=0.
//   - ADD 0x0000_0000_FFFF_FFFF + 0x1 (carry across slice boundaries) -> sum=0x0000_0001_0000_0000, ovf=0.
//   - SUB 3-4 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0; SUB 5-5 -> sum=0, zero=1, cout=1;
//     SUB 0x8000_0000_0000_0000-1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
//   - Back-to-back 8 ADDs (i+1, i=0..7) with out_ready low cycles 6-8 -> in_ready low those cycles,
//     results 1..8 emerge in order, none lost or repeated.
//   - rst asserted 2 cycles after 3 accepted items -> out_valid=0 next cycle, no stale result ever emerges;
//     next accepted item 1+2 gives 3 after 4 cyc.
//   - Sweep STAGES in {1,2,8} with random ops vs. behavioural a±b model -> all fields match, latency=STAGES.

Source files
------------

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined two's-complement adder/subtractor for the EX-stage ALU.
// The carry chain is cut into STAGES slices of CH = WIDTH/STAGES bits. Stage k adds
// slice k and registers it, together with the full operands and the lower sum slices
// already produced (skew), so each slot carries its whole operation down the pipe.
// WIDTH must be a multiple of STAGES, and 1 <= STAGES <= WIDTH.
//
// Handshake (valid/ready): an item moves in when in_valid && in_ready and moves out
// when out_valid && out_ready. The whole pipe advances together whenever the output
// slot is empty or being drained (advance = !out_valid || out_ready), and
// in_ready = advance. On a stall every stage holds, so nothing is dropped, duplicated
// or reordered. Empty slots travel as valid=0 bubbles.
module add_sub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CH = WIDTH / STAGES;

  // Per-stage registered slot contents. b_q already holds B' (inverted for SUB).
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             zero_q;

  // What each stage sees on its input side (stage 0: the ports, stage k: stage k-1).
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];

  // Next-state of each stage after adding its own slice.
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             zero_d;
  logic [CH:0]      slice_sum;

  logic advance;

  assign advance  = !v_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  // Route stage inputs and add one CH-bit slice per stage.
  always_comb begin
    slice_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_v[k] = 1'b0;
      src_a[k] = '0;
      src_b[k] = '0;
      src_s[k] = '0;
      src_c[k] = 1'b0;
      s_d[k]   = '0;
      c_d[k]   = 1'b0;
    end
    // SUB is A + ~B + 1: invert B once here and inject the +1 as stage 0 carry-in.
    src_v[0] = in_valid;
    src_a[0] = in_a;
    src_b[0] = in_sub ? ~in_b : in_b;
    src_s[0] = '0;
    src_c[0] = in_sub;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, src_a[k][k*CH +: CH]} + {1'b0, src_b[k][k*CH +: CH]}
                + {{CH{1'b0}}, src_c[k]};
      s_d[k]             = src_s[k];
      s_d[k][k*CH +: CH] = slice_sum[CH-1:0];
      c_d[k]             = slice_sum[CH];
    end
    zero_d = ~|s_d[STAGES-1];
  end

  // Shift the pipe on advance; slot data only loads for valid items so the output
  // slot keeps the last valid result and flags while bubbles pass through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (src_v[STAGES-1]) begin
        zero_q <= zero_d;
      end
    end
  end

  // Final-stage results. Overflow: operands A and B' agree in sign but the sum does not.
  // All final-stage registers reset to 0, so ovf reads 0 out of reset.
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_zero  = zero_q;
  assign out_ovf   = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                     (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_add_sub_pipe.sv
// Testbench for add_sub_pipe: four instances (STAGES = 4, 1, 2, 8; WIDTH = 64) share
// clock and reset. Directed cases run on the STAGES=4 instance; random sweeps run on
// each instance in turn against a plain-arithmetic reference model.
module tb_add_sub_pipe;

  localparam int W     = 64;
  localparam int N_DUT = 4;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid  [N_DUT];
  logic         in_sub    [N_DUT];
  logic         out_ready [N_DUT];
  logic [W-1:0] in_a      [N_DUT];
  logic [W-1:0] in_b      [N_DUT];
  wire          in_ready  [N_DUT];
  wire          out_valid [N_DUT];
  wire          out_cout  [N_DUT];
  wire          out_ovf   [N_DUT];
  wire          out_zero  [N_DUT];
  wire  [W-1:0] out_sum   [N_DUT];

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected sum, expected {zero, ovf, cout}, acceptance cycle.
  logic [W-1:0] exp_q  [$];
  logic [2:0]   flag_q [$];
  int           acc_q  [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(W), .STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_sub(in_sub[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_cout(out_cout[0]),
    .out_ovf(out_ovf[0]), .out_zero(out_zero[0]));

  add_sub_pipe #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_sub(in_sub[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(out_sum[1]), .out_cout(out_cout[1]),
    .out_ovf(out_ovf[1]), .out_zero(out_zero[1]));

  add_sub_pipe #(.WIDTH(W), .STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_sub(in_sub[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_sum(out_sum[2]), .out_cout(out_cout[2]),
    .out_ovf(out_ovf[2]), .out_zero(out_zero[2]));

  add_sub_pipe #(.WIDTH(W), .STAGES(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(in_a[3]), .in_b(in_b[3]), .in_sub(in_sub[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_sum(out_sum[3]), .out_cout(out_cout[3]),
    .out_ovf(out_ovf[3]), .out_zero(out_zero[3]));

  function automatic int stages_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  // Reference model: {zero, ovf, cout, sum} from exact integer arithmetic.
  // cout for SUB is "no borrow", i.e. a >= b unsigned. ovf when the exact signed
  // result does not fit in W bits.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0]          u;
    logic signed [W+1:0] s;
    logic [W-1:0]        sum;
    logic                cout;
    logic                ovf;
    if (sub) begin
      u    = {1'b0, a} - {1'b0, b};
      cout = (a >= b);
      s    = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
    end else begin
      u    = {1'b0, a} + {1'b0, b};
      cout = u[W];
      s    = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
    end
    sum = u[W-1:0];
    ovf = (s != $signed({{2{sum[W-1]}}, sum}));
    return {(sum == '0), ovf, cout, sum};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h0;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int i = 0; i < N_DUT; i++) begin
      in_valid[i]  = 1'b0;
      in_sub[i]    = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
      out_ready[i] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]);
      end
      checks++;
      if (out_sum[i] !== '0) begin
        errors++; $display("FAIL reset_out_sum[%0d]: got %h want 0", i, out_sum[i]);
      end
      checks++;
      if ({out_zero[i], out_ovf[i], out_cout[i]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got zero/ovf/cout=%b%b%b want 000",
                 i, out_zero[i], out_ovf[i], out_cout[i]);
      end
      checks++;
      if (in_ready[i] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta   [5];
    logic [W-1:0] tb_v [5];
    logic         tsub [5];
    logic [W-1:0] tsum [5];
    logic [2:0]   tfl  [5];   // {zero, ovf, cout}
    ta[0] = 64'h7FFF_FFFF_FFFF_FFFF; tb_v[0] = 64'h2; tsub[0] = 1'b0;
    tsum[0] = 64'h8000_0000_0000_0001; tfl[0] = 3'b010;
    ta[1] = 64'h0000_0000_FFFF_FFFF; tb_v[1] = 64'h1; tsub[1] = 1'b0;
    tsum[1] = 64'h0000_0001_0000_0000; tfl[1] = 3'b000;
    ta[2] = 64'd3; tb_v[2] = 64'd4; tsub[2] = 1'b1;
    tsum[2] = 64'hFFFF_FFFF_FFFF_FFFF; tfl[2] = 3'b000;
    ta[3] = 64'd5; tb_v[3] = 64'd5; tsub[3] = 1'b1;
    tsum[3] = 64'h0; tfl[3] = 3'b101;
    ta[4] = 64'h8000_0000_0000_0000; tb_v[4] = 64'd1; tsub[4] = 1'b1;
    tsum[4] = 64'h7FFF_FFFF_FFFF_FFFF; tfl[4] = 3'b011;
    out_ready[0] = 1'b1;
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b1; in_a[0] = ta[v]; in_b[0] = tb_v[v]; in_sub[0] = tsub[v];
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b1) begin
        errors++; $display("FAIL dir%0d_in_ready: got %b want 1", v, in_ready[0]);
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0; in_a[0] = {$urandom(), $urandom()}; in_b[0] = {$urandom(), $urandom()};
      in_sub[0] = ~tsub[v];
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (out_valid[0] !== 1'b0) begin
          errors++; $display("FAIL dir%0d_early_valid@%0d: got %b want 0", v, k, out_valid[0]);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid[0] !== 1'b1) begin
        errors++; $display("FAIL dir%0d_out_valid: got %b want 1", v, out_valid[0]);
      end
      checks++;
      if (out_sum[0] !== tsum[v]) begin
        errors++; $display("FAIL dir%0d_sum: got %h want %h", v, out_sum[0], tsum[v]);
      end
      checks++;
      if ({out_zero[0], out_ovf[0], out_cout[0]} !== tfl[v]) begin
        errors++;
        $display("FAIL dir%0d_flags: got zero/ovf/cout=%b%b%b want %b",
                 v, out_zero[0], out_ovf[0], out_cout[0], tfl[v]);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid[0] !== 1'b0 || out_sum[0] !== tsum[v]) begin
        errors++;
        $display("FAIL dir%0d_hold: got valid=%b sum=%h want valid=0 sum=%h",
                 v, out_valid[0], out_sum[0], tsum[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    bit stall;
    exp_q.delete();
    @(posedge clk); #1;
    for (int t = 0; t < 40 && got < 8; t++) begin
      stall        = (t >= 6 && t <= 8);
      in_valid[0]  = (sent < 8);
      in_a[0]      = 64'(sent);
      in_b[0]      = 64'd1;
      in_sub[0]    = 1'b0;
      out_ready[0] = !stall;
      @(negedge clk);
      checks++;
      if (in_ready[0] !== !stall) begin
        errors++; $display("FAIL b2b_in_ready@%0d: got %b want %b", t, in_ready[0], !stall);
      end
      if (stall && exp_q.size() > 0) begin
        checks++;
        if (out_valid[0] !== 1'b1 || out_sum[0] !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_stall_hold@%0d: got valid=%b sum=%h want valid=1 sum=%h",
                   t, out_valid[0], out_sum[0], exp_q[0]);
        end
      end
      if (in_valid[0] && in_ready[0]) begin
        exp_q.push_back(64'(sent + 1));
        sent++;
      end
      if (out_valid[0] && out_ready[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious@%0d: got sum=%h want no output", t, out_sum[0]);
        end else begin
          if (out_sum[0] !== exp_q[0]) begin
            errors++; $display("FAIL b2b_order@%0d: got %h want %h", t, out_sum[0], exp_q[0]);
          end
          void'(exp_q.pop_front());
          got++;
        end
      end
      @(posedge clk); #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    checks++;
    if (got !== 8 || sent !== 8) begin
      errors++; $display("FAIL b2b_count: got out=%0d in=%0d want 8 and 8", got, sent);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      in_valid[0] = 1'b1; in_a[0] = 64'(t + 10); in_b[0] = 64'd1; in_sub[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b1) begin
        errors++; $display("FAIL rstmid_accept%0d: got in_ready=%b want 1", t, in_ready[0]);
      end
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid_after_rst: got %b want 0", out_valid[0]);
    end
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b0) begin
        errors++; $display("FAIL rstmid_stale@%0d: got valid=%b sum=%h want valid=0",
                           t, out_valid[0], out_sum[0]);
      end
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_a[0] = 64'd1; in_b[0] = 64'd2; in_sub[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 1;
    while (out_valid[0] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL rstmid_latency: got %0d want 4", lat);
    end
    checks++;
    if (out_sum[0] !== 64'd3) begin
      errors++; $display("FAIL rstmid_sum: got %h want 3", out_sum[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep(input int idx, input int n_a, input int n_b);
    int           s_lat = stages_of(idx);
    bit           hold  = 1'b0;
    bit           phase_a;
    int           acc;
    logic [W+2:0] m;
    exp_q.delete(); flag_q.delete(); acc_q.delete();
    @(posedge clk); #1;
    for (int t = 0; t < n_a + n_b; t++) begin
      phase_a        = (t < n_a);
      out_ready[idx] = phase_a ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid[idx] = ($urandom_range(0, 9) < 7);
        in_a[idx]     = pick_operand();
        in_b[idx]     = ($urandom_range(0, 7) == 0) ? in_a[idx] : pick_operand();
        in_sub[idx]   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (in_valid[idx] && in_ready[idx]) begin
        m = model(in_a[idx], in_b[idx], in_sub[idx]);
        exp_q.push_back(m[W-1:0]);
        flag_q.push_back(m[W+2:W]);
        acc_q.push_back(t);
        hold = 1'b0;
      end else begin
        hold = in_valid[idx];
      end
      if (out_valid[idx] && out_ready[idx]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep%0d_spurious@%0d: got sum=%h want no output", idx, t, out_sum[idx]);
        end else begin
          if (out_sum[idx] !== exp_q[0]) begin
            errors++;
            $display("FAIL sweep%0d_sum@%0d: got %h want %h", idx, t, out_sum[idx], exp_q[0]);
          end
          checks++;
          if ({out_zero[idx], out_ovf[idx], out_cout[idx]} !== flag_q[0]) begin
            errors++;
            $display("FAIL sweep%0d_flags@%0d: got zero/ovf/cout=%b%b%b want %b",
                     idx, t, out_zero[idx], out_ovf[idx], out_cout[idx], flag_q[0]);
          end
          acc = acc_q[0];
          if (phase_a) begin
            checks++;
            if (t - acc !== s_lat) begin
              errors++;
              $display("FAIL sweep%0d_latency@%0d: got %0d want %0d", idx, t, t - acc, s_lat);
            end
          end
          void'(exp_q.pop_front()); void'(flag_q.pop_front()); void'(acc_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) begin
      @(negedge clk);
      if (out_valid[idx]) begin
        checks++;
        if (out_sum[idx] !== exp_q[0] ||
            {out_zero[idx], out_ovf[idx], out_cout[idx]} !== flag_q[0]) begin
          errors++;
          $display("FAIL sweep%0d_drain: got sum=%h flags=%b%b%b want sum=%h flags=%b", idx,
                   out_sum[idx], out_zero[idx], out_ovf[idx], out_cout[idx], exp_q[0], flag_q[0]);
        end
        void'(exp_q.pop_front()); void'(flag_q.pop_front()); void'(acc_q.pop_front());
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep%0d_lost: got %0d results missing want 0", idx, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < N_DUT; i++) begin
      test_sweep(i, 60, 140);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got simulation still running want finished");
    $fatal(1, "timeout");
  end

endmodule
